// File: rtl/mult_seq_16bit.sv
// Sequential 16x16 unsigned shift-and-add multiplier with a start/done handshake.
// A ripple full_adder_16bit performs one partial-product add per RUN cycle.

module full_adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [16:0] carry;

  assign carry[0] = cin;

  genvar i;
  generate
    for (i = 0; i < 16; i++) begin : g_bit
      assign sum[i]     = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign cout = carry[16];

endmodule

module mult_seq_16bit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   add_b;
  logic [WIDTH-1:0]   sum;
  logic               c;
  logic [2*WIDTH-1:0] shifted;

  // Adding zero when the multiplier bit is clear keeps the carry at 0, giving {1'b0, acc_hi}.
  assign add_b   = acc_lo[0] ? mcand : '0;
  assign shifted = {c, sum, acc_lo[WIDTH-1:1]};

  full_adder_16bit u_adder (
    .a    (acc_hi),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (sum),
    .cout (c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start && !abort) next_state = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (abort)                next_state = IDLE;
        else if (cnt == CNT_LAST) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      mcand   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            mcand  <= a;
            acc_lo <= b;
            acc_hi <= '0;
            cnt    <= '0;
          end
        end
        RUN: begin
          if (!abort) begin
            {acc_hi, acc_lo} <= shifted;
            cnt              <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST) product <= shifted;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_16bit.sv
// Directed and randomised bench for mult_seq_16bit; inputs change and outputs are sampled on
// the falling edge so every rising edge sees settled values.

module tb_mult_seq_16bit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] a;
  logic [15:0] b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int          tests;
  int          failures;
  logic [31:0] last_product;

  mult_seq_16bit #(.WIDTH(16), .CNT_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Entered on a falling edge with ready=1; returns on the falling edge where ready is back.
  // Cycle k is the k-th cycle after the acceptance edge; done must appear in cycle 17.
  task automatic apply_stimulus(input logic [15:0] op_a, input logic [15:0] op_b,
                                input int glitch_cycle);
    logic [31:0] expected;
    expected = {16'h0, op_a} * {16'h0, op_b};
    check_output("ready_before_start", 32'(ready), 32'd1);
    start = 1'b1;
    a     = op_a;
    b     = op_b;
    @(negedge clk);
    start = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
    check_output("busy_after_accept", 32'(busy), 32'd1);
    for (int cyc = 1; cyc <= 16; cyc++) begin
      if (cyc == glitch_cycle) begin
        start = 1'b1;
        a     = 16'h0001;
        b     = 16'h0001;
      end else begin
        start = 1'b0;
      end
      check_output("done_early", 32'(done), 32'd0);
      check_output("product_held", product, last_product);
      check_output("onehot_state", 32'($onehot0({ready, busy, done})), 32'd1);
      @(negedge clk);
    end
    start = 1'b0;
    check_output("done_at_17", 32'(done), 32'd1);
    check_output("busy_in_done", 32'(busy), 32'd0);
    check_output("ready_in_done", 32'(ready), 32'd0);
    check_output("product", product, expected);
    last_product = expected;
    @(negedge clk);
    check_output("ready_return", 32'(ready), 32'd1);
    check_output("done_single", 32'(done), 32'd0);
  endtask

  initial begin
    tests        = 0;
    failures     = 0;
    last_product = 32'h0;
    rst_n        = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    a            = 16'h0;
    b            = 16'h0;

    repeat (2) @(negedge clk);
    check_output("reset_ready", 32'(ready), 32'd1);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    check_output("reset_product", product, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    apply_stimulus(16'd3, 16'd5, 0);
    apply_stimulus(16'hFFFF, 16'hFFFF, 0);
    check_output("ffff_sq_const", product, 32'hFFFE0001);
    apply_stimulus(16'h1234, 16'h0000, 0);
    apply_stimulus(16'h0000, 16'h1234, 0);
    apply_stimulus(16'd3, 16'd5, 0);
    check_output("prior_15", product, 32'h0000000F);

    // Abort in RUN cycle 5 returns to IDLE with no done and the old product.
    start = 1'b1;
    a     = 16'd7;
    b     = 16'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check_output("busy_before_abort", 32'(busy), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_output("abort_ready", 32'(ready), 32'd1);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_done", 32'(done), 32'd0);
    check_output("abort_product", product, 32'h0000000F);
    for (int i = 0; i < 20; i++) begin
      check_output("abort_no_done", 32'(done), 32'd0);
      @(negedge clk);
    end

    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    check_output("abort_wins_ready", 32'(ready), 32'd1);
    check_output("abort_wins_busy", 32'(busy), 32'd0);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check_output("abort_wins_idle", 32'(ready), 32'd1);
    check_output("abort_wins_product", product, 32'h0000000F);

    apply_stimulus(16'h00FF, 16'h0101, 4);
    apply_stimulus(16'h1234, 16'h5678, 0);
    check_output("b2b_const", product, 32'h06260060);

    // Asynchronous reset in RUN cycle 8.
    start = 1'b1;
    a     = 16'hABCD;
    b     = 16'h4321;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check_output("busy_before_reset", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("midrun_reset_product", product, 32'h0);
    check_output("midrun_reset_ready", 32'(ready), 32'd1);
    check_output("midrun_reset_busy", 32'(busy), 32'd0);
    check_output("midrun_reset_done", 32'(done), 32'd0);
    last_product = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check_output("post_reset_no_done", 32'(done), 32'd0);
      check_output("post_reset_ready", 32'(ready), 32'd1);
      @(negedge clk);
    end

    apply_stimulus(16'hFFFF, 16'h0001, 0);
    apply_stimulus(16'h8000, 16'h8000, 0);
    check_output("msb_sq_const", product, 32'h40000000);

    for (int i = 0; i < 1000; i++) begin
      apply_stimulus(16'($urandom), 16'($urandom), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
